// File: rtl/priority_rr_arbiter.sv
// rtl/priority_rr_arbiter.sv - fixed-priority / round-robin arbiter with bounded grant tenure
module priority_rr_arbiter #(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 mode,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 busy
);

    localparam int IW = $clog2(N);
    localparam int CW = (MAX_HOLD < 2) ? 2 : $clog2(MAX_HOLD + 1);
    localparam bit LIMITED = (MAX_HOLD != 0);
    localparam logic [CW-1:0] HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t        state, next_state;
    logic [IW-1:0] owner, next_owner;
    logic [IW-1:0] last_owner, next_last_owner;
    logic [CW-1:0] count, next_count;

    logic [N-1:0]  owner_mask;
    logic [N-1:0]  eligible;
    logic          any_eligible;
    logic          keep;
    logic [IW-1:0] fx_idx;
    logic [IW-1:0] rr_idx;
    logic          rr_found;
    logic [IW-1:0] winner;
    int            rr_pos;

    always_comb begin
        owner_mask        = '0;
        owner_mask[owner] = 1'b1;
    end

    // The current owner never competes in a re-arbitration; when it has
    // dropped its request the mask is a no-op anyway.
    assign eligible     = (state == GRANT) ? (req & ~owner_mask) : req;
    assign any_eligible = |eligible;
    assign keep         = req[owner] && (!LIMITED || (count < HOLD_MAX));

    always_comb begin
        fx_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (eligible[i]) begin
                fx_idx = IW'(i);
            end
        end
    end

    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_pos   = 0;
        for (int i = 1; i <= N; i++) begin
            rr_pos = (int'(last_owner) + i) % N;
            if (!rr_found && eligible[rr_pos]) begin
                rr_found = 1'b1;
                rr_idx   = IW'(rr_pos);
            end
        end
    end

    assign winner = mode ? rr_idx : fx_idx;

    always_comb begin
        next_state      = state;
        next_owner      = owner;
        next_last_owner = last_owner;
        next_count      = count;
        case (state)
            IDLE: begin
                if (any_eligible) begin
                    next_state      = GRANT;
                    next_owner      = winner;
                    next_last_owner = winner;
                    next_count      = CW'(1);
                end
            end
            GRANT: begin
                if (keep) begin
                    if (LIMITED || (count != '1)) begin
                        next_count = count + 1'b1;
                    end
                end else if (any_eligible) begin
                    next_owner      = winner;
                    next_last_owner = winner;
                    next_count      = CW'(1);
                end else if (req[owner]) begin
                    // Tenure expired with nobody else waiting: re-grant in place.
                    next_last_owner = owner;
                    next_count      = CW'(1);
                end else begin
                    next_state = IDLE;
                    next_owner = '0;
                    next_count = '0;
                end
            end
            default: begin
                next_state = IDLE;
                next_owner = '0;
                next_count = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_IDX;
            count      <= '0;
            grant      <= '0;
            grant_idx  <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= next_state;
            owner      <= next_owner;
            last_owner <= next_last_owner;
            count      <= next_count;
            busy       <= (next_state == GRANT);
            grant_idx  <= (next_state == GRANT) ? next_owner : '0;
            grant      <= '0;
            if (next_state == GRANT) begin
                grant[next_owner] <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// tb/tb_priority_rr_arbiter.sv - self-checking bench for priority_rr_arbiter
module tb_priority_rr_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 4;

    logic         clk;
    logic         reset;
    logic [N-1:0] req;
    logic         mode;
    logic [N-1:0] grant;
    logic [1:0]   grant_idx;
    logic         busy;

    int total = 0;
    int bad   = 0;
    bit check_en = 0;

    // Reference model: who holds the grant, how long, and who held it last.
    bit m_busy  = 0;
    int m_owner = 0;
    int m_cnt   = 0;
    int m_last  = N - 1;

    priority_rr_arbiter #(.N(N), .MAX_HOLD(HOLD)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .mode      (mode),
        .grant     (grant),
        .grant_idx (grant_idx),
        .busy      (busy)
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic int pick(input logic [N-1:0] r, input int excl, input bit md, input int last);
        if (!md) begin
            for (int i = N - 1; i >= 0; i--)
                if (r[i] && i != excl) return i;
        end else begin
            for (int s = 1; s <= N; s++) begin
                int c;
                c = (last + s) % N;
                if (r[c] && c != excl) return c;
            end
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        int w;
        if (reset) begin
            m_busy = 0; m_owner = 0; m_cnt = 0; m_last = N - 1;
        end else if (!m_busy) begin
            w = pick(req, -1, mode, m_last);
            if (w >= 0) begin
                m_busy = 1; m_owner = w; m_cnt = 1; m_last = w;
            end
        end else if (req[m_owner] && m_cnt < HOLD) begin
            m_cnt++;
        end else begin
            w = pick(req, m_owner, mode, m_last);
            if (w >= 0) begin
                m_owner = w; m_cnt = 1; m_last = w;
            end else if (req[m_owner]) begin
                m_cnt = 1;
            end else begin
                m_busy = 0; m_owner = 0; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        int ei;
        if (check_en) begin
            eg = m_busy ? (N'(1) << m_owner) : '0;
            ei = m_busy ? m_owner : 0;
            total++;
            if (grant !== eg || grant_idx !== 2'(ei) || busy !== m_busy) begin
                bad++;
                $display("FAIL model t=%0t: actual grant=%b idx=%0d busy=%b required grant=%b idx=%0d busy=%b",
                         $time, grant, grant_idx, busy, eg, ei, m_busy);
            end
        end
    end

    task automatic expect_lit(input string name, input logic [N-1:0] eg, input int ei, input bit eb);
        total++;
        if (grant !== eg || grant_idx !== 2'(ei) || busy !== eb) begin
            bad++;
            $display("FAIL %s: actual grant=%b idx=%0d busy=%b required grant=%b idx=%0d busy=%b",
                     name, grant, grant_idx, busy, eg, ei, eb);
        end
    endtask

    task automatic step(input logic [N-1:0] r, input bit md, input bit rs);
        req = r; mode = md; reset = rs;
        @(negedge clk);
    endtask

    logic [N-1:0] vec_req  [8] = '{4'b1010, 4'b1010, 4'b0011, 4'b0011, 4'b0000, 4'b0101, 4'b1100, 4'b1111};
    bit           vec_mode [8] = '{1, 1, 0, 1, 0, 1, 0, 1};

    initial begin
        req = '0; mode = 0; reset = 1;
        @(negedge clk);
        @(negedge clk);
        check_en = 1;
        expect_lit("reset_state", 4'b0000, 0, 0);

        step(4'b0000, 0, 0);
        expect_lit("idle_no_req", 4'b0000, 0, 0);

        step(4'b0110, 0, 0);
        expect_lit("fixed_0110", 4'b0100, 2, 1);

        for (int k = 0; k < 10; k++) begin
            step(4'b0100, 0, 0);
            expect_lit($sformatf("hold_regrant_%0d", k), 4'b0100, 2, 1);
        end
        step(4'b0000, 0, 0);
        expect_lit("drop_to_idle", 4'b0000, 0, 0);

        step(4'b0000, 1, 1);
        expect_lit("reset_again", 4'b0000, 0, 0);
        for (int k = 0; k <= 16; k++) begin
            int e;
            e = (k / 4) % 4;
            step(4'b1111, 1, 0);
            expect_lit($sformatf("rr_rotate_%0d", k), N'(1) << e, e, 1);
        end

        step(4'b1000, 1, 0);
        expect_lit("owner_drop_handoff", 4'b1000, 3, 1);

        step(4'b0000, 0, 0);
        expect_lit("idle_before_expiry", 4'b0000, 0, 0);
        for (int k = 0; k <= 8; k++) begin
            step(4'b1001, 0, 0);
            if (k < 4 || k == 8) expect_lit($sformatf("fixed_expiry_%0d", k), 4'b1000, 3, 1);
            else                 expect_lit($sformatf("fixed_expiry_%0d", k), 4'b0001, 0, 1);
        end

        step(4'b1111, 1, 0);
        expect_lit("mode_change_mid_tenure_a", 4'b1000, 3, 1);
        step(4'b1111, 1, 0);
        expect_lit("mode_change_mid_tenure_b", 4'b1000, 3, 1);
        step(4'b1111, 1, 1);
        expect_lit("reset_mid_tenure", 4'b0000, 0, 0);
        step(4'b1111, 1, 0);
        expect_lit("rr_after_reset", 4'b0001, 0, 1);

        for (int v = 0; v < 8; v++) begin
            for (int c = 0; c < 3; c++) step(vec_req[v], vec_mode[v], 0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/priority_rr_arbiter.md
PRIORITY_RR_ARBITER -- requirements
Module: priority_rr_arbiter

Interface
REQ-001 The block SHALL have parameter N, default 4, giving the number of requesters (legal range 2..16).
REQ-002 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grant cycles per tenure (0 = unlimited).
REQ-003 Port clk, input, 1 bit, SHALL be the clock; all state SHALL update on its rising edge.
REQ-004 Port reset, input, 1 bit, SHALL be the reset: synchronous, active-high.
REQ-005 Port req, input, N bits, SHALL carry one request bit per requester (level-sensitive).
REQ-006 Port mode, input, 1 bit, SHALL select the policy: 0 = fixed priority (highest index wins), 1 = round-robin.
REQ-007 Port grant, output, N bits, SHALL be a registered, one-hot-or-zero grant vector.
REQ-008 Port grant_idx, output, clog2(N) bits, SHALL be the registered index of the granted requester (0 when no grant).
REQ-009 Port busy, output, 1 bit, SHALL be registered high whenever grant is non-zero.

Function
REQ-010 The FSM SHALL have two states: IDLE (grant = 0) and GRANT (exactly one grant bit set).
REQ-011 In IDLE, if any req bit is set at a rising edge, the block SHALL enter GRANT with the winner's grant bit set after that edge (1-cycle latency).
REQ-012 In IDLE with req = 0, the block SHALL stay in IDLE with grant = 0.
REQ-013 Fixed mode SHALL select the highest set index among eligible requesters.
REQ-014 Round-robin mode SHALL select the first eligible set index searching upward from last_owner+1, wrapping modulo N.
REQ-015 last_owner SHALL update to the winner index on every grant decision in either mode.
REQ-016 mode SHALL be sampled only at the edges where a grant decision is made; a mode change during a tenure SHALL NOT disturb the current grant.
REQ-017 A hold counter SHALL be set to 1 on each new grant and SHALL increment each cycle the grant is kept, saturating at MAX_HOLD.
REQ-018 In GRANT, while req[owner] = 1 and (MAX_HOLD = 0 or count < MAX_HOLD), the grant SHALL remain unchanged.
REQ-019 If req[owner] = 0 at an edge, the block SHALL re-arbitrate among the remaining set bits in the same edge: a winner receives the grant with no idle cycle, otherwise the block SHALL go to IDLE with grant = 0.
REQ-020 On expiry (req[owner] = 1 and count = MAX_HOLD, MAX_HOLD > 0), the block SHALL re-arbitrate excluding the owner.
REQ-021 On expiry with no other requester, the block SHALL re-grant the owner: grant stays asserted and count restarts at 1.
REQ-022 In every state, grant, grant_idx and busy SHALL remain mutually consistent at all times.
REQ-023 With MAX_HOLD = 1 and two or more requesters continuously asserted, round-robin mode SHALL rotate the grant every cycle.

Reset
REQ-024 When reset = 1 at a rising edge, the next state SHALL be IDLE with grant = 0, grant_idx = 0, busy = 0, count = 0 and last_owner = N-1, so the first round-robin search starts at index 0.
REQ-025 Reset SHALL take priority over all requests, including during an active grant.
REQ-026 The first grant decision SHALL occur at the first edge with reset = 0.

Verification (N=4, MAX_HOLD=4 unless stated)
REQ-027 Fixed mode, IDLE, req=0110 -> after 1 edge grant=0100, grant_idx=2, busy=1.
REQ-028 Fixed mode, req=0100 held 10 cycles -> grant=0100 continuous with no gap (re-grant at cycles 4 and 8); then req=0000 -> next edge grant=0000, busy=0.
REQ-029 Round-robin mode, req=1111 held after reset -> grant sequence 0001, 0010, 0100, 1000, 0001, each held 4 cycles.
REQ-030 Owner 0 drops req while req=1000 -> next edge grant=1000, grant_idx=3, no idle cycle.
REQ-031 Fixed mode expiry: owner 3 with req=1001 held -> after 4 cycles grant=0001, after 4 more grant=1000.
REQ-032 Reset asserted mid-tenure with req=1111 -> next edge grant=0000; after release, round-robin grant=0001.
